// File: rtl/async_rx_bridge.sv
// async_rx_bridge: clocked receiver for a 4-phase bundled-data push channel.
// Synchronises req_in, captures data, completes the handshake, buffers in a FIFO.
module async_rx_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_in,
  output logic                     ack_out,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];

  logic req_s;
  logic full;
  logic push;
  logic pop;

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign full      = (count_q == CW'(DEPTH));
  assign ack_out   = (state_q == ACK);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign count     = count_q;
  assign pop       = out_valid && out_ready;

  // Shift req_in through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
  end

  // Handshake FSM: capture on request when space, release on request fall
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage, pointers and occupancy; full/empty decided by count only
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = data_in;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_async_rx_bridge.sv
// tb_async_rx_bridge: directed bench for async_rx_bridge.
// Scoreboard queue filled on stimulus, drained when the DUT pops.
module tb_async_rx_bridge;

  logic       clk;
  logic       reset;
  logic       req_in;
  logic       ack_out;
  logic [7:0] data_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  int max_cnt;
  logic [7:0] sbq [$];

  async_rx_bridge #(
    .WIDTH(8),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_in(req_in),
    .ack_out(ack_out),
    .data_in(data_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    for (int i = 0; i < 50 && ack_out !== lvl; i++) tick();
    chk(tag, {31'b0, ack_out}, {31'b0, lvl});
  endtask

  task automatic send(input logic [7:0] d);
    data_in = d;
    req_in  = 1'b1;
    sbq.push_back(d);
    wait_ack(1'b1, "send_ack_rise");
    req_in = 1'b0;
    wait_ack(1'b0, "send_ack_fall");
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ready = 1'b0;
  endtask

  // Scoreboard: compare head against expected on every accepted pop
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      tests++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow: got pop of %0h expected none", out_data);
      end
      if (sbq.size() != 0) chk("sb_data", {24'b0, out_data},
                               {24'b0, sbq.pop_front()});
    end
  end

  initial begin
    reset     = 1'b1;
    req_in    = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    max_cnt   = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ack", {31'b0, ack_out}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_data", {24'b0, out_data}, 0);

    // single token with exact latency
    data_in = 8'hA5;
    req_in  = 1'b1;
    sbq.push_back(8'hA5);
    tick();
    chk("t1_ack_e1", {31'b0, ack_out}, 0);
    tick();
    chk("t1_ack_e2", {31'b0, ack_out}, 0);
    tick();
    chk("t1_ack_e3", {31'b0, ack_out}, 1);
    chk("t1_valid_e3", {31'b0, out_valid}, 1);
    chk("t1_data_e3", {24'b0, out_data}, 32'hA5);
    req_in = 1'b0;
    tick();
    chk("t1_fall_e1", {31'b0, ack_out}, 1);
    tick();
    chk("t1_fall_e2", {31'b0, ack_out}, 1);
    tick();
    chk("t1_fall_e3", {31'b0, ack_out}, 0);
    chk("t1_count", {29'b0, count}, 1);
    drain(1);
    chk("t1_count_drained", {29'b0, count}, 0);

    // fill to full, then backpressure
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("t2_full_count", {29'b0, count}, 4);
    data_in = 8'h05;
    req_in  = 1'b1;
    sbq.push_back(8'h05);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_bp_ack", {31'b0, ack_out}, 0);
    chk("t2_bp_count", {29'b0, count}, 4);
    drain(1);
    chk("t2_pop_no_push", {29'b0, count}, 3);
    for (int i = 0; i < 2 && ack_out !== 1'b1; i++) tick();
    chk("t2_ack_after_pop", {31'b0, ack_out}, 1);
    chk("t2_refill_count", {29'b0, count}, 4);
    req_in = 1'b0;
    wait_ack(1'b0, "t2_ack_fall");
    drain(6);
    chk("t2_drained", {29'b0, count}, 0);
    chk("t2_sb_empty", sbq.size(), 0);

    // simultaneous push and pop at count=2
    send(8'h20);
    send(8'h21);
    data_in = 8'h22;
    req_in  = 1'b1;
    sbq.push_back(8'h22);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_ack", {31'b0, ack_out}, 1);
    chk("t3_count", {29'b0, count}, 2);
    chk("t3_head", {24'b0, out_data}, 32'h21);
    req_in = 1'b0;
    wait_ack(1'b0, "t3_ack_fall");
    drain(3);
    chk("t3_drained", {29'b0, count}, 0);

    // streaming wrap-around
    out_ready = 1'b1;
    max_cnt   = 0;
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
    tick();
    out_ready = 1'b0;
    chk("t4_max_count", max_cnt, 1);
    chk("t4_count", {29'b0, count}, 0);
    chk("t4_sb_empty", sbq.size(), 0);

    // reset mid-handshake
    send(8'h30);
    send(8'h31);
    data_in = 8'h32;
    req_in  = 1'b1;
    wait_ack(1'b1, "t5_ack_rise");
    chk("t5_pre_count", {29'b0, count}, 3);
    reset = 1'b1;
    tick();
    sbq.delete();
    chk("t5_rst_ack", {31'b0, ack_out}, 0);
    chk("t5_rst_count", {29'b0, count}, 0);
    chk("t5_rst_valid", {31'b0, out_valid}, 0);
    reset = 1'b0;
    sbq.push_back(8'h32);
    tick();
    chk("t5_re_e1", {31'b0, ack_out}, 0);
    tick();
    chk("t5_re_e2", {31'b0, ack_out}, 0);
    tick();
    chk("t5_re_e3", {31'b0, ack_out}, 1);
    chk("t5_re_count", {29'b0, count}, 1);
    req_in = 1'b0;
    wait_ack(1'b0, "t5_ack_fall");
    drain(2);
    chk("t5_drained", {29'b0, count}, 0);

    // pop while empty is ignored
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_count", {29'b0, count}, 0);
      chk("t6_valid", {31'b0, out_valid}, 0);
    end
    out_ready = 1'b0;
    send(8'h40);
    chk("t6_data", {24'b0, out_data}, 32'h40);
    drain(2);
    chk("t6_sb_empty", sbq.size(), 0);
    chk("t6_count_end", {29'b0, count}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
